bus_bridge_ws: RTL

BUS_BRIDGE_WS -- requirements
Module: bus_bridge_ws

---
 rtl/bus_bridge_ws_if.sv | 31 +++
 rtl/bus_bridge_ws.sv | 106 ++++++++++
 2 files changed

// File: rtl/bus_bridge_ws_if.sv
// bus_bridge_ws_if: CPU-side and device-side signal bundle for the wait-state bridge.
interface bus_bridge_ws_if #(
  parameter int NDEV   = 4,
  parameter int DEV_AW = 4
) ();
  logic                   cpu_req;
  logic                   cpu_we;
  logic [29:0]            cpu_addr;
  logic [31:0]            cpu_wdata;
  logic [31:0]            cpu_rdata;
  logic                   cpu_ready;
  logic                   cpu_err;
  logic                   busy;
  logic [DEV_AW-1:0]      dev_addr;
  logic [31:0]            dev_wdata;
  logic [NDEV-1:0]        dev_we;
  logic [NDEV-1:0]        dev_re;
  logic [32*NDEV-1:0]     dev_rdata;
  logic [NDEV-1:0]        dev_ack;
  logic [7:0]             err_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_ack,
    output cpu_rdata, cpu_ready, cpu_err, busy, dev_addr, dev_wdata, dev_we, dev_re, err_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_ack,
    input  cpu_rdata, cpu_ready, cpu_err, busy, dev_addr, dev_wdata, dev_we, dev_re, err_cnt
  );
endinterface

// File: rtl/bus_bridge_ws.sv
// bus_bridge_ws: CPU-to-device bridge with address decode, write protection,
// per-device wait states with timeout, and a saturating error counter.
module bus_bridge_ws #(
  parameter int                 NDEV    = 4,
  parameter int                 DEV_AW  = 4,
  parameter int                 TIMEOUT = 15,
  parameter logic [32*NDEV-1:0] BASE    = {32'h00009000, 32'h00007F00, 32'h00008100, 32'h00008000},
  parameter logic [32*NDEV-1:0] MASK    = {32'hFFFFF000, 32'hFFFFFF00, 32'hFFFFFFF0, 32'hFFFFFFF0},
  parameter logic [NDEV-1:0]    WMASK   = 4'b1110
) (
  input logic             clk,
  input logic             rst_n,
  bus_bridge_ws_if.slave  bus
);
  localparam int CW = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [NDEV-1:0]   hit, sel_d, sel_q;
  logic              we_q, permit, ack, accept;
  logic [DEV_AW-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, rdata_d, rsel;
  logic              err_q, err_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [7:0]        ecnt_q;

  for (genvar g = 0; g < NDEV; g++) begin : g_dec
    assign hit[g] = (({bus.cpu_addr, 2'b00} & MASK[32*g +: 32]) == BASE[32*g +: 32]);
  end

  // Isolate the lowest set hit bit so the lowest-index device wins overlaps.
  assign sel_d  = hit & (~hit + NDEV'(1));
  assign permit = |sel_d && !(bus.cpu_we && |(sel_d & ~WMASK));
  assign accept = (state_q == IDLE) && bus.cpu_req;
  assign ack    = |(bus.dev_ack & sel_q);

  always_comb begin
    rsel = '0;
    for (int i = 0; i < NDEV; i++) rsel = rsel | (sel_q[i] ? bus.dev_rdata[32*i +: 32] : 32'h0);
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (bus.cpu_req) begin
        state_d = permit ? ACCESS : RESP;
        wcnt_d  = '0;
        err_d   = permit ? err_q : 1'b1;
        rdata_d = permit ? rdata_q : 32'h0;
      end
      ACCESS: if (ack) begin
        state_d = RESP;
        err_d   = 1'b0;
        rdata_d = we_q ? 32'h0 : rsel;
      end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
        state_d = RESP;
        err_d   = 1'b1;
        rdata_d = 32'h0;
      end else begin
        wcnt_d = wcnt_q + CW'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        sel_q   <= sel_d;
        we_q    <= bus.cpu_we;
        addr_q  <= bus.cpu_addr[DEV_AW-1:0];
        wdata_q <= bus.cpu_wdata;
      end
      if (state_q == RESP && err_q && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
    end
  end

  assign bus.dev_we    = (state_q == ACCESS &&  we_q) ? sel_q : '0;
  assign bus.dev_re    = (state_q == ACCESS && !we_q) ? sel_q : '0;
  assign bus.dev_addr  = addr_q;
  assign bus.dev_wdata = wdata_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_err   = err_q;
  assign bus.cpu_ready = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
  assign bus.err_cnt   = ecnt_q;
endmodule
